// File: rtl/t02_muldiv_unit_if.sv
// rtl/t02_muldiv_unit_if.sv - request/write-back bundle between the core and the mul/div unit
//
// Purpose: groups the operation request (start, funct3, rd_index, operands) and the
// write-back response (busy, done, result, reg_write, write_index).
// master: the core side (drives the request, observes the response).
// slave : the mul/div unit (consumes the request, drives the response).
interface t02_muldiv_unit_if #(
    parameter int XLEN = 32
);
    logic            start;
    logic [2:0]      funct3;
    logic [4:0]      rd_index;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] result;
    logic            reg_write;
    logic [4:0]      write_index;

    modport master (
        output start, funct3, rd_index, rs1_data, rs2_data,
        input  busy, done, result, reg_write, write_index
    );

    modport slave (
        input  start, funct3, rd_index, rs1_data, rs2_data,
        output busy, done, result, reg_write, write_index
    );
endinterface

// File: rtl/t02_muldiv_unit.sv
// rtl/t02_muldiv_unit.sv - iterative RV32M multiply/divide unit, fixed 33-cycle latency
//
// Purpose: shift-add multiply (64-bit product) and restoring divide, one bit per clock,
// on operand magnitudes; signs are reapplied when the result is captured.
// Ports:
//   clk    - system clock, rising edge
//   RST    - asynchronous active-high reset
//   s_mdu  - slave side of t02_muldiv_unit_if (request in, write-back request out)
module t02_muldiv_unit #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 5
) (
    input  logic              clk,
    input  logic              RST,
    t02_muldiv_unit_if.slave  s_mdu
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = {CNT_W{1'b1}};

    state_t              r_state;
    state_t              w_state_nxt;
    logic [CNT_W-1:0]    r_cnt;
    logic [2:0]          r_funct3;
    logic [4:0]          r_rd;
    logic                r_neg_a;
    logic                r_neg_b;
    logic                r_div0;
    // r_opc: fixed operand (multiplicand for MUL*, divisor for DIV*/REM*)
    // r_hi : product high half / partial remainder
    // r_lo : multiplier bits being consumed / dividend shifting out, quotient shifting in
    logic [XLEN-1:0]     r_opc;
    logic [XLEN-1:0]     r_hi;
    logic [XLEN-1:0]     r_lo;
    logic [XLEN-1:0]     r_result;

    logic                w_accept;
    logic                w_signed_a;
    logic                w_signed_b;
    logic                w_in_neg_a;
    logic                w_in_neg_b;
    logic [XLEN-1:0]     w_abs_a;
    logic [XLEN-1:0]     w_abs_b;

    logic [XLEN:0]       w_madd;
    logic [XLEN:0]       w_dshift;
    logic                w_dfit;
    logic [XLEN-1:0]     w_dsub;
    logic [XLEN-1:0]     w_hi_nxt;
    logic [XLEN-1:0]     w_lo_nxt;

    logic [2*XLEN-1:0]   w_prod;
    logic [2*XLEN-1:0]   w_prod_s;
    logic [XLEN-1:0]     w_quo;
    logic [XLEN-1:0]     w_rem;
    logic [XLEN-1:0]     w_final;

    // Request decode: which operands are treated as signed for this funct3.
    always_comb begin
        w_signed_a = (s_mdu.funct3 != 3'b011) && (s_mdu.funct3 != 3'b101) && (s_mdu.funct3 != 3'b111);
        w_signed_b = (s_mdu.funct3 == 3'b000) || (s_mdu.funct3 == 3'b001) ||
                     (s_mdu.funct3 == 3'b100) || (s_mdu.funct3 == 3'b110);
        w_in_neg_a = w_signed_a && s_mdu.rs1_data[XLEN-1];
        w_in_neg_b = w_signed_b && s_mdu.rs2_data[XLEN-1];
        w_abs_a    = w_in_neg_a ? (~s_mdu.rs1_data + 1'b1) : s_mdu.rs1_data;
        w_abs_b    = w_in_neg_b ? (~s_mdu.rs2_data + 1'b1) : s_mdu.rs2_data;
    end

    assign w_accept = (r_state == ST_IDLE) && s_mdu.start;

    // One iteration step for both algorithms; r_funct3[2] picks divide.
    always_comb begin
        w_madd   = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_opc} : '0);
        w_dshift = {r_hi, r_lo[XLEN-1]};
        w_dfit   = (w_dshift >= {1'b0, r_opc});
        // When the divisor fits, the difference is below 2^XLEN, so XLEN-bit
        // arithmetic on the low bits is exact.
        w_dsub   = w_dshift[XLEN-1:0] - r_opc;
        if (r_funct3[2]) begin
            w_hi_nxt = w_dfit ? w_dsub : w_dshift[XLEN-1:0];
            w_lo_nxt = {r_lo[XLEN-2:0], w_dfit};
        end else begin
            w_hi_nxt = w_madd[XLEN:1];
            w_lo_nxt = {w_madd[0], r_lo[XLEN-1:1]};
        end
    end

    // Final result from the last iteration's values, captured on the edge into DONE.
    // Divide by zero naturally yields remainder = |dividend| (signed back to rs1), but
    // the quotient must be forced to all ones regardless of sign flags.
    always_comb begin
        w_prod   = {w_hi_nxt, w_lo_nxt};
        w_prod_s = (r_neg_a ^ r_neg_b) ? (~w_prod + 1'b1) : w_prod;
        w_quo    = r_div0 ? {XLEN{1'b1}} :
                   ((r_neg_a ^ r_neg_b) ? (~w_lo_nxt + 1'b1) : w_lo_nxt);
        w_rem    = r_neg_a ? (~w_hi_nxt + 1'b1) : w_hi_nxt;
        w_final  = '0;
        case (r_funct3)
            3'b000:                 w_final = w_prod_s[XLEN-1:0];
            3'b001, 3'b010, 3'b011: w_final = w_prod_s[2*XLEN-1:XLEN];
            3'b100, 3'b101:         w_final = w_quo;
            default:                w_final = w_rem;
        endcase
    end

    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (s_mdu.start) w_state_nxt = ST_CALC;
            ST_CALC: if (r_cnt == CNT_LAST) w_state_nxt = ST_DONE;
            ST_DONE: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            r_cnt    <= '0;
            r_funct3 <= '0;
            r_rd     <= '0;
            r_neg_a  <= 1'b0;
            r_neg_b  <= 1'b0;
            r_div0   <= 1'b0;
            r_opc    <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_result <= '0;
        end else if (w_accept) begin
            r_cnt    <= '0;
            r_funct3 <= s_mdu.funct3;
            r_rd     <= s_mdu.rd_index;
            r_neg_a  <= w_in_neg_a;
            r_neg_b  <= w_in_neg_b;
            r_div0   <= (s_mdu.rs2_data == '0);
            r_opc    <= s_mdu.funct3[2] ? w_abs_b : w_abs_a;
            r_lo     <= s_mdu.funct3[2] ? w_abs_a : w_abs_b;
            r_hi     <= '0;
        end else if (r_state == ST_CALC) begin
            r_cnt <= r_cnt + 1'b1;
            r_hi  <= w_hi_nxt;
            r_lo  <= w_lo_nxt;
            if (r_cnt == CNT_LAST) begin
                r_result <= w_final;
            end
        end
    end

    assign s_mdu.busy        = (r_state != ST_IDLE);
    assign s_mdu.done        = (r_state == ST_DONE);
    assign s_mdu.reg_write   = (r_state == ST_DONE) && (r_rd != 5'd0);
    assign s_mdu.write_index = r_rd;
    assign s_mdu.result      = r_result;

endmodule

// File: tb/tb_t02_muldiv_unit.sv
// tb/tb_t02_muldiv_unit.sv - scoreboard bench for t02_muldiv_unit
module tb_t02_muldiv_unit;

    typedef struct {
        logic [31:0] res;
        logic        rw;
        logic [4:0]  wi;
        int          c0;
        string       name;
    } exp_t;

    logic clk;
    logic rst;
    int   cyc;
    int   checks;
    int   errors;
    int   n_done;
    exp_t sb[$];

    t02_muldiv_unit_if #(.XLEN(32)) mdu_if ();

    t02_muldiv_unit #(.XLEN(32), .CNT_W(5)) dut (
        .clk   (clk),
        .RST   (rst),
        .s_mdu (mdu_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard on every done pulse.
    always @(negedge clk) begin
        exp_t e;
        if (mdu_if.reg_write) chk("reg_write_without_done", {31'd0, mdu_if.done}, 32'd1);
        if (mdu_if.done) begin
            n_done++;
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got result %h expected no done", mdu_if.result);
            end else begin
                e = sb.pop_front();
                chk({e.name, "_result"}, mdu_if.result, e.res);
                chk({e.name, "_reg_write"}, {31'd0, mdu_if.reg_write}, {31'd0, e.rw});
                chk({e.name, "_write_index"}, {27'd0, mdu_if.write_index}, {27'd0, e.wi});
                chk({e.name, "_latency"}, cyc - e.c0, 32'd32);
            end
        end
    end

    // Launch one request at the next edge; operands are scrambled right after.
    task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, input logic [31:0] exp, input string name,
                         input bit push);
        exp_t e;
        @(negedge clk);
        mdu_if.start    = 1'b1;
        mdu_if.funct3   = f;
        mdu_if.rs1_data = a;
        mdu_if.rs2_data = b;
        mdu_if.rd_index = rd;
        if (push) begin
            e.res = exp; e.rw = (rd != 5'd0); e.wi = rd; e.c0 = cyc + 1; e.name = name;
            sb.push_back(e);
        end
        @(negedge clk);
        mdu_if.start    = 1'b0;
        mdu_if.funct3   = 3'($urandom);
        mdu_if.rs1_data = $urandom;
        mdu_if.rs2_data = $urandom;
        mdu_if.rd_index = 5'($urandom);
    endtask

    task automatic drain();
        for (int i = 0; i < 60 && sb.size() != 0; i++) @(negedge clk);
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: got %0d pending expected 0", sb.size());
            sb.delete();
        end
        @(negedge clk);
    endtask

    task automatic run(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, input logic [31:0] exp, input string name);
        issue(f, a, b, rd, exp, name, 1'b1);
        drain();
    endtask

    initial begin
        int d0;
        cyc    = 0;
        checks = 0;
        errors = 0;
        n_done = 0;
        rst    = 1'b1;
        mdu_if.start    = 1'b0;
        mdu_if.funct3   = 3'd0;
        mdu_if.rs1_data = 32'd0;
        mdu_if.rs2_data = 32'd0;
        mdu_if.rd_index = 5'd0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("reset_busy",        {31'd0, mdu_if.busy},        32'd0);
        chk("reset_done",        {31'd0, mdu_if.done},        32'd0);
        chk("reset_reg_write",   {31'd0, mdu_if.reg_write},   32'd0);
        chk("reset_result",      mdu_if.result,               32'd0);
        chk("reset_write_index", {27'd0, mdu_if.write_index}, 32'd0);

        run(3'b000, 32'd7,        32'hFFFFFFFD, 5'd5,  32'hFFFFFFEB, "mul_7_m3");
        run(3'b001, 32'h80000000, 32'h80000000, 5'd6,  32'h40000000, "mulh_min_min");
        run(3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd7,  32'hFFFFFFFE, "mulhu_max");
        run(3'b010, 32'hFFFFFFFF, 32'h00000002, 5'd8,  32'hFFFFFFFF, "mulhsu_m1_2");
        run(3'b011, 32'h80000000, 32'h00000002, 5'd31, 32'h00000001, "mulhu_2p31_2");
        run(3'b101, 32'd100,      32'd0,        5'd9,  32'hFFFFFFFF, "divu_by0");
        run(3'b111, 32'd100,      32'd0,        5'd10, 32'd100,      "remu_by0");
        run(3'b100, 32'hFFFFFFFB, 32'd0,        5'd11, 32'hFFFFFFFF, "div_m5_by0");
        run(3'b110, 32'hFFFFFFFB, 32'd0,        5'd12, 32'hFFFFFFFB, "rem_m5_by0");
        run(3'b100, 32'hFFFFFFF9, 32'd2,        5'd13, 32'hFFFFFFFD, "div_m7_2");
        run(3'b110, 32'hFFFFFFF9, 32'd2,        5'd14, 32'hFFFFFFFF, "rem_m7_2");
        run(3'b100, 32'd20,       32'hFFFFFFFD, 5'd15, 32'hFFFFFFFA, "div_20_m3");
        run(3'b110, 32'd20,       32'hFFFFFFFD, 5'd16, 32'd2,        "rem_20_m3");
        run(3'b100, 32'h80000000, 32'hFFFFFFFF, 5'd17, 32'h80000000, "div_ovf");
        run(3'b110, 32'h80000000, 32'hFFFFFFFF, 5'd18, 32'd0,        "rem_ovf");

        // rd=0 with a second start pulsed at E10 while busy
        d0 = n_done;
        issue(3'b000, 32'd3, 32'd4, 5'd0, 32'd12, "mul_rd0", 1'b1);
        repeat (8) @(negedge clk);
        mdu_if.start    = 1'b1;
        mdu_if.funct3   = 3'b101;
        mdu_if.rs1_data = 32'd55;
        mdu_if.rs2_data = 32'd5;
        mdu_if.rd_index = 5'd3;
        @(negedge clk);
        mdu_if.start = 1'b0;
        drain();
        repeat (40) @(negedge clk);
        chk("busy_start_single_done", n_done - d0, 32'd1);

        // Reset in the middle of a divide
        d0 = n_done;
        issue(3'b101, 32'd1000, 32'd7, 5'd9, 32'd0, "divu_reset", 1'b0);
        repeat (14) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("midreset_busy",   {31'd0, mdu_if.busy}, 32'd0);
        chk("midreset_result", mdu_if.result,        32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (30) @(negedge clk);
        chk("midreset_no_done", n_done - d0, 32'd0);
        chk("midreset_result_hold", mdu_if.result, 32'd0);

        run(3'b101, 32'd1000, 32'd7, 5'd20, 32'd142, "divu_after_reset");
        run(3'b111, 32'd1000, 32'd7, 5'd21, 32'd6,   "remu_after_reset");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
